// File: rtl/insn_encoder.sv
// insn_encoder: turns instruction descriptors into 32-bit MIPS-style words and
// streams them into an instruction memory, one word per cycle, inserting NOP
// padding after branches/jumps (BR_PAD words) and loads (LD_PAD words).
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   clear             synchronous restart (address 0, full/err cleared, IDLE)
//   in_valid/in_ready descriptor handshake, accepted when both high at a rising edge
//   in_op             0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SLT, 6 ADDI, 7 LOAD,
//                     8 STORE, 9 BEQ, 10 JMP, 11-15 invalid
//   in_rs/rt/rd       register fields; in_imm immediate; in_target jump target
//   imem_we/addr/wdata registered write port, valid the cycle after acceptance
//   full              every word of the 2^ADDR_W memory has been written
//   err_op            sticky flag: an invalid opcode was accepted
module insn_encoder #(
  parameter int ADDR_W = 8,
  parameter int BR_PAD = 2,
  parameter int LD_PAD = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              full,
  output logic              err_op
);

  typedef enum logic {IDLE, PAD} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [2:0]        BR_N      = 3'(BR_PAD);
  localparam logic [2:0]        LD_N      = 3'(LD_PAD);

  state_t            state;
  logic [2:0]        pad_cnt;
  logic [ADDR_W-1:0] waddr;   // address the next word will be written to

  logic [31:0] enc_word;
  logic        op_ok;
  logic [2:0]  pad_n;
  logic        accept;

  // Gated by reset_n so the handshake stays closed while reset is held, and by
  // clear so a descriptor offered during a restart is never taken.
  assign in_ready = reset_n && (state == IDLE) && !full && !clear;
  assign accept   = in_valid && in_ready;

  always_comb begin
    enc_word = '0;
    op_ok    = 1'b1;
    pad_n    = '0;
    case (in_op)
      4'd0:  enc_word = '0;
      4'd1:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h20};
      4'd2:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h22};
      4'd3:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h24};
      4'd4:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h25};
      4'd5:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2A};
      4'd6:  enc_word = {6'h08, in_rs, in_rt, in_imm};
      4'd7: begin
        enc_word = {6'h20, in_rs, in_rt, in_imm};
        pad_n    = LD_N;
      end
      4'd8:  enc_word = {6'h30, in_rs, in_rt, in_imm};
      4'd9: begin
        enc_word = {6'h04, in_rs, in_rt, in_imm};
        pad_n    = BR_N;
      end
      4'd10: begin
        enc_word = {6'h02, in_target};
        pad_n    = BR_N;
      end
      default: op_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pad_cnt    <= '0;
      waddr      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      full       <= 1'b0;
      err_op     <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      pad_cnt    <= '0;
      waddr      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      full       <= 1'b0;
      err_op     <= 1'b0;
    end else begin
      imem_we    <= 1'b0;
      imem_wdata <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!op_ok) begin
              err_op <= 1'b1;
            end else begin
              imem_we    <= 1'b1;
              imem_addr  <= waddr;
              imem_wdata <= enc_word;
              // Writing the last word freezes the address and skips any padding.
              if (waddr == LAST_ADDR) begin
                full <= 1'b1;
              end else begin
                waddr <= waddr + 1'b1;
                if (pad_n != '0) begin
                  state   <= PAD;
                  pad_cnt <= pad_n;
                end
              end
            end
          end
        end
        PAD: begin
          imem_we    <= 1'b1;
          imem_addr  <= waddr;
          imem_wdata <= '0;
          if (waddr == LAST_ADDR) begin
            full    <= 1'b1;
            state   <= IDLE;
            pad_cnt <= '0;
          end else begin
            waddr   <= waddr + 1'b1;
            pad_cnt <= pad_cnt - 1'b1;
            if (pad_cnt == 3'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/insn_encoder.md
INSN_ENCODER -- requirements
Module: insn_encoder

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory word-address width.
REQ-002 Parameter BR_PAD, default 2, NOP words emitted after each BEQ/JMP (0..7).
REQ-003 Parameter LD_PAD, default 1, NOP words emitted after each LOAD (0..7).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 clear  input  1  synchronous restart: address to 0, full cleared, FSM to IDLE.
REQ-007 in_valid  input  1  descriptor present.
REQ-008 in_ready  output  1  descriptor accepted when in_valid && in_ready at rising edge.
REQ-009 in_op  input  4  0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SLT, 6 ADDI, 7 LOAD, 8 STORE, 9 BEQ, 10 JMP; 11-15 invalid.
REQ-010 in_rs, in_rt, in_rd  input  5 each  register fields.
REQ-011 in_imm  input  16  immediate/offset; in_target  input  26  jump target.
REQ-012 imem_we  output  1  write strobe, one word per cycle.
REQ-013 imem_addr  output  ADDR_W  word address of current write.
REQ-014 imem_wdata  output  32  encoded instruction word.
REQ-015 full  output  1  all 2^ADDR_W words written.
REQ-016 err_op  output  1  sticky: invalid in_op accepted.

Function
REQ-017 Encoding SHALL be: R-type opcode 0x00, rs[25:21], rt[20:16], rd[15:11], shamt 0, funct ADD 0x20/SUB 0x22/AND 0x24/OR 0x25/SLT 0x2A.
REQ-018 ADDI 0x08, LOAD 0x20, STORE 0x30, BEQ 0x04 SHALL be opcode|rs|rt|imm[15:0]; JMP 0x02 SHALL be opcode|target[25:0]; NOP SHALL be 32'h0.
REQ-019 Latency: descriptor accepted at edge t SHALL appear as imem_we=1 with encoded word during cycle t+1 (registered outputs).
REQ-020 FSM states IDLE, PAD; IDLE: in_ready = !full; accepted BEQ/JMP with BR_PAD>0 or LOAD with LD_PAD>0 -> PAD with pad counter loaded; else remain IDLE (throughput 1 word/cycle).
REQ-021 PAD: in_ready=0, one NOP word written per cycle at successive addresses, counter decrements; after last NOP returns to IDLE.
REQ-022 imem_addr SHALL increment by 1 after every write; on write to address 2^ADDR_W-1, full SHALL set, address holds, imem_we never asserts again until clear/reset.
REQ-023 full reached inside PAD: remaining pads dropped, FSM to IDLE.
REQ-024 Invalid in_op: accepted (in_ready=1), no write, address unchanged, err_op set and held until clear/reset.
REQ-025 in_op=0 SHALL write a literal NOP word (no padding).
REQ-026 clear has priority over in_valid in same cycle; descriptor presented that cycle is not accepted.
REQ-027 Input fields are sampled only on acceptance; changes while in_ready=0 SHALL have no effect.

Reset
REQ-028 While reset_n=0: imem_we=0, imem_addr=0, imem_wdata=0, full=0, err_op=0, in_ready=0, FSM IDLE, pad counter 0.
REQ-029 Reset asserted mid-PAD SHALL abandon pending NOPs; first cycle after deassertion in_ready=1.

Verification
REQ-030 ADD rs=1 rt=2 rd=3 accepted -> next cycle imem_we=1, addr 0, wdata 32'h00221820.
REQ-031 BEQ rs=4 rt=5 imm=16'hFFFE, BR_PAD=2 -> words 32'h1085FFFE, 0, 0 at addr 0,1,2; in_ready low 2 cycles; back-to-back ADDI written at addr 3.
REQ-032 LOAD rs=0 rt=7 imm=4 then JMP target=26'h10 -> 32'h80070004, NOP, 32'h08000010, NOP, NOP at addr 0-4.
REQ-033 ADDR_W=2: five ADDIs offered continuously -> four written (addr 0-3), full=1 after fourth, in_ready=0, fifth never written; clear -> addr 0, full=0.
REQ-034 in_op=12 -> no imem_we, err_op=1 sticky through later valid writes; reset_n pulse mid-PAD -> outputs zero immediately, no further NOPs.
